// File: rtl/goomba_sprite_reader.sv
// Goomba sprite reader: maps the VGA beam position onto a sprite RAM address,
// optionally mirrored, and returns the opaque palette index three cycles later.
// A small ALIVE/SQUASH/DEAD state machine controls which rows are visible.
module goomba_sprite_reader #(
    parameter int unsigned SPR_W         = 22,
    parameter int unsigned SPR_H         = 30,
    parameter int unsigned SQUASH_FRAMES = 30,
    parameter logic [3:0]  TRANSPARENT   = 4'h0
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        pix_en,
    input  logic        frame_start,
    input  logic [9:0]  sprite_x,
    input  logic [9:0]  sprite_y,
    input  logic        face_left,
    input  logic        kill,
    input  logic        revive,
    input  logic [3:0]  data_in,
    output logic [18:0] READ_ADDR,
    output logic        pix_hit,
    output logic [3:0]  pix_idx,
    output logic [1:0]  state_o
);

    localparam int unsigned CNT_W = (SQUASH_FRAMES > 1) ? $clog2(SQUASH_FRAMES) : 1;

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        SQUASH = 2'd1,
        DEAD   = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   squash_cnt;
    logic [9:0]         sx, sy;
    logic               face_sh;

    logic [10:0]        col, row, c;
    logic               in_box, visible;
    logic [18:0]        addr_next;

    logic               in_box_d1, vis_d1;
    logic               in_box_d2, vis_d2;

    assign state_o = state;

    // Stage-1 combinational: box test, mirrored column, RAM address, visibility
    always_comb begin
        col    = {1'b0, DrawX} - {1'b0, sx};
        row    = {1'b0, DrawY} - {1'b0, sy};
        in_box = pix_en && (DrawX >= sx) && (DrawY >= sy) &&
                 (col < 11'(SPR_W)) && (row < 11'(SPR_H));
        c      = face_sh ? (11'(SPR_W - 1) - col) : col;
        addr_next = 19'(row) * 19'(SPR_W) + 19'(c);
        case (state)
            ALIVE:   visible = 1'b1;
            SQUASH:  visible = (row >= 11'(SPR_H / 2));
            default: visible = 1'b0;
        endcase
    end

    // Shadow position latch and sprite life-cycle state machine
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            sx         <= '0;
            sy         <= '0;
            face_sh    <= 1'b0;
            state      <= ALIVE;
            squash_cnt <= '0;
        end else begin
            if (frame_start) begin
                sx      <= sprite_x;
                sy      <= sprite_y;
                face_sh <= face_left;
            end
            if (revive) begin
                state      <= ALIVE;
                squash_cnt <= '0;
            end else begin
                case (state)
                    ALIVE: begin
                        // a frame_start coinciding with kill is not counted
                        if (kill) begin
                            state      <= SQUASH;
                            squash_cnt <= '0;
                        end
                    end
                    SQUASH: begin
                        if (frame_start) begin
                            if (squash_cnt == CNT_W'(SQUASH_FRAMES - 1))
                                state <= DEAD;
                            else
                                squash_cnt <= squash_cnt + 1'b1;
                        end
                    end
                    default: state <= DEAD;
                endcase
            end
        end
    end

    // Stage 1: register RAM address (held when outside the box) and flags
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            READ_ADDR <= '0;
            in_box_d1 <= 1'b0;
            vis_d1    <= 1'b0;
        end else begin
            if (in_box)
                READ_ADDR <= addr_next;
            in_box_d1 <= in_box;
            vis_d1    <= visible;
        end
    end

    // Stage 2: delay flags to line up with the RAM read data
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            in_box_d2 <= 1'b0;
            vis_d2    <= 1'b0;
        end else begin
            in_box_d2 <= in_box_d1;
            vis_d2    <= vis_d1;
        end
    end

    // Stage 3: opaque-pixel decision and palette index output
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            pix_hit <= 1'b0;
            pix_idx <= '0;
        end else begin
            if (in_box_d2 && vis_d2 && (data_in != TRANSPARENT)) begin
                pix_hit <= 1'b1;
                pix_idx <= data_in;
            end else begin
                pix_hit <= 1'b0;
                pix_idx <= '0;
            end
        end
    end

endmodule
